// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: a cycle counter plus NUM_EVT qualified event
// counters, an auto-stop cycle limit, atomic shadow snapshot and a registered read port.
module pipe_perf_cnt #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module pipe_perf_monitor #(
  parameter int NUM_EVT  = 4,
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1,
  localparam int SEL_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] evt_kill_i,
  input  logic               clear_i,
  input  logic               snapshot_i,
  input  logic               rd_req_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic               rd_vld_o,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               done_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                        state_q, state_d;
  logic                          count_en;
  logic [NUM_EVT:0]              inc;
  logic [NUM_EVT:0][CNT_W-1:0]   cnt;
  logic [NUM_EVT:0][CNT_W-1:0]   shd_q;
  logic [CNT_W-1:0]              cyc_nxt;
  logic                          lim_hit;
  logic                          rd_vld_q;
  logic [CNT_W-1:0]              rd_data_q, rd_data_d;

  // Lane 0 is the cycle counter; lane k is event channel k-1.
  assign count_en = (state_q == RUN) & start_i & ~clear_i;
  assign inc      = {evt_i & ~evt_kill_i & {NUM_EVT{count_en}}, count_en};

  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_lane
    pipe_perf_cnt #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (inc[g]),
      .cnt_o (cnt[g]),
      .ovf_o (ovf_o[g])
    );
  end

  // Limit compares against the post-increment value, so a wrap to 0 never matches.
  assign cyc_nxt = (&cnt[0]) ? (SATURATE ? cnt[0] : '0) : cnt[0] + CNT_W'(1);
  assign lim_hit = count_en & (limit_i != '0) & (cyc_nxt == limit_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !clear_i) state_d = RUN;
      RUN:     if (clear_i) state_d = IDLE;
               else if (lim_hit) state_d = DONE;
      DONE:    if (clear_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_req_i) rd_data_d = (rd_sel_i <= SEL_W'(NUM_EVT)) ? shd_q[rd_sel_i] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shd_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= rd_req_i;
      rd_data_q <= rd_data_d;
      // Captures pre-increment / pre-clear live values.
      if (snapshot_i) shd_q <= cnt;
    end
  end

  assign rd_vld_o  = rd_vld_q;
  assign rd_data_o = rd_data_q;
  assign done_o    = (state_q == DONE);
  assign busy_o    = (state_q == RUN);
endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Synthesizable pipeline performance monitor for the five-stage CPU. It counts run cycles and up to NUM_EVT qualified pipeline events, such as load-use stalls and branch flushes, and stops automatically after a programmable cycle limit. Counters can be snapshotted atomically into shadow registers and read back through a one-cycle-latency read port. The block sits beside the CPU top level and is fed from the hazard-detection and branch logic.

## Interface
- NUM_EVT, 4, number of event channels (1..15)
- CNT_W, 32, width of every counter and of rd_data_o
- SATURATE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  count enable; counting happens only in RUN with start_i=1
- limit_i  in  CNT_W  cycle limit; 0 = unlimited
- evt_i  in  NUM_EVT  raw event strobes, one bit per channel
- evt_kill_i  in  NUM_EVT  per-channel qualifier; an event counts only if evt_i[k] & ~evt_kill_i[k]
- clear_i  in  1  zero live counters and overflow flags; return to IDLE
- snapshot_i  in  1  copy all live counters into shadow registers
- rd_req_i  in  1  read request
- rd_sel_i  in  $clog2(NUM_EVT+1)  index 0 = cycle counter; index k = event channel k-1
- rd_vld_o  out  1  read data valid
- rd_data_o  out  CNT_W  shadow value of the selected counter
- ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1
- done_o  out  1  high while the FSM is in DONE
- busy_o  out  1  high while the FSM is in RUN

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: start_i=1.
  - RUN→DONE: the cycle counter increments to a value equal to a nonzero limit_i.
  - DONE→IDLE and RUN→IDLE: clear_i=1.
  - IDLE→IDLE: start_i=0.
- In RUN with start_i=1, every cycle the cycle counter increments by 1. Channel k increments when evt_i[k]&~evt_kill_i[k].
- In RUN with start_i=0, all counters hold and the FSM stays in RUN (pause).
- Events in the cycle that reaches the limit are counted. Nothing is counted in IDLE or DONE.
- Overflow, when a counter at all-ones is asked to increment:
  - SATURATE=1: the counter holds at all-ones.
  - SATURATE=0: the counter becomes 0.
  - In both modes the matching ovf_o bit sets and stays set until clear_i or rst_i.
- With SATURATE=0 and limit_i nonzero, the limit compare uses the post-increment value, so wrap past the limit never occurs before DONE.
- clear_i zeroes the live counters and ovf_o and forces IDLE. It does not touch the shadow registers.
- Snapshot:
  - snapshot_i copies the live values as they stand before this cycle's increment. The same-cycle increment still lands in the live counters.
  - snapshot_i with clear_i in the same cycle captures the pre-clear values.
- Read:
  - A rd_req_i=1 in cycle N gives rd_vld_o=1 in N+1, with rd_data_o = the shadow value selected by rd_sel_i as of cycle N.
  - rd_sel_i > NUM_EVT returns 0 with rd_vld_o=1.
  - Reads are accepted every cycle, back-to-back, in any FSM state.
- Priority, highest first: rst_i, clear_i, counting. snapshot_i is independent of the others.

## Timing
- Reset values: all live and shadow counters 0, ovf_o=0, rd_vld_o=0, rd_data_o=0, done_o=0, busy_o=0, FSM=IDLE.
- rst_i asserted mid-run aborts immediately; the next cycle is IDLE with all state zero.
- start_i sampled high in IDLE at edge N: busy_o=1 after edge N. The first count happens at edge N+1 if start_i is still 1.
- With limit_i=L, the cycle counter reads L and done_o=1 after exactly L counted edges.
- limit_i is sampled every cycle. Lowering it below the current count in RUN never triggers DONE; it runs until equality or wrap.
- Read latency is 1 cycle. rd_vld_o is 1 cycle wide per request.
- Snapshot-to-read: a snapshot at edge N is visible to a rd_req_i sampled at edge N+1 or later. A read sampled at edge N returns the old shadow.

## Test plan
- Limit stop: NUM_EVT=2, limit_i=30, start_i held 1, evt_i[0] pulsed every 3rd cycle, evt_i[1]=0 → done_o rises after 30 counted edges. Cycle count 30, ch0=10, ch1=0. Counts remain frozen 5 cycles later.
- Kill qualifier: evt_i[0]=1 for 8 cycles with evt_kill_i[0]=1 on 3 of them → ch0=5. Then snapshot; rd_sel_i=1 → rd_vld_o next cycle with rd_data_o=5.
- Pause: run 4 cycles, drop start_i for 6 cycles, raise for 2 cycles → cycle count 6, busy_o=1 throughout, done_o=0.
- Overflow: CNT_W=4, limit_i=0, run 17 cycles.
  - SATURATE=1: cycle count 15, ovf_o[0]=1.
  - SATURATE=0: cycle count 1, ovf_o[0]=1.
- Same-cycle events: snapshot_i and clear_i together at cycle count 12 → shadow cycle=12, live=0, FSM=IDLE. A read in the same cycle returns the previous shadow value; a read one cycle later returns 12.
- Mid-run reset: rst_i at cycle 7 of RUN → all outputs 0 next cycle. rd_sel_i=NUM_EVT+1 (out of range) returns 0 with rd_vld_o=1.
